axi_stream_insert_header: RTL and testbench
===========================================

Name: axi_stream_insert_header

Overview:
- AXI-Stream header inserter: one header word per packet (data_insert/keep_insert) is merged ahead of the payload on data_in.
- The valid header bytes are prepended to the payload and the result is re-packed into full output beats.
- Sits between a packet source and a downstream AXI-Stream sink. Single clock domain.

Parameters:
- DATA_WD, 32, data bus width in bits (multiple of 8).
- DATA_BYTE_WD, DATA_WD/8, bytes per beat (N).
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte_insert_cnt.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset; synchronous, active-high: reset is asserted when rst_n=1.
- valid_in  input  1  payload beat valid.
- data_in  input  DATA_WD  payload; byte 0 = bits [DATA_WD-1:DATA_WD-8], first on the wire.
- keep_in  input  DATA_BYTE_WD  byte enables, MSB-aligned; only meaningful when last_in=1 (e.g. 1110); all-ones otherwise.
- last_in  input  1  final payload beat.
- ready_in  output  1  payload accept.
- valid_out  output  1  output beat valid.
- data_out  output  DATA_WD  merged stream.
- keep_out  output  DATA_BYTE_WD  MSB-aligned byte enables.
- last_out  output  1  final output beat.
- ready_out  input  1  downstream ready.
- valid_insert  input  1  header valid.
- data_insert  input  DATA_WD  header word; valid bytes are LSB-aligned.
- keep_insert  input  DATA_BYTE_WD  header enables, LSB-contiguous (0000, 0001, 0011, 0111, 1111).
- byte_insert_cnt  input  BYTE_CNT_WD  header byte count mod N; informational only, not used by datapath.
- ready_insert  output  1  header accept.

Behaviour:
- Handshakes: a transfer occurs on a rising edge where valid and ready are both 1.
- Header length: H = popcount(keep_insert), 0..N. H=0 gives pure pass-through.
- States: IDLE -> DATA -> TAIL (optional) -> IDLE.
- IDLE:
  - ready_insert=1, ready_in=0.
  - On header transfer: latch the H low bytes of data_insert into the residual register R, store H, go to DATA.
- DATA:
  - ready_insert=0.
  - ready_in = !valid_out | ready_out (one-deep registered output).
  - Each accepted payload beat with H>0: data_out <= {R (H bytes), top N-H bytes of data_in}; R <= low H bytes of data_in. valid_out <= 1.
  - With H=0: data_out <= data_in.
- Last payload beat (last_in=1), with k = popcount(keep_in) and T = H+k:
  - T <= N: emit one beat, keep_out = T MSB-aligned ones, last_out=1, go to IDLE.
  - T > N: emit a full beat (keep_out all ones, last_out=0), go to TAIL.
- TAIL:
  - ready_in=0, ready_insert=0.
  - When the output register is free, emit data_out = {R, zeros}, keep_out = T-N MSB ones, last_out=1, go to IDLE.
- Output enables and zeroing:
  - Non-last beats have keep_out = all ones.
  - Bytes outside keep_out are driven 0.
- Output register:
  - valid_out clears when ready_out=1 and no new beat is loaded.
  - data_out, keep_out and last_out hold stable while valid_out=1 and ready_out=0.
- Latency: 1 cycle from payload acceptance to valid_out.
- Back-to-back packets: the next header may be accepted in the cycle the state returns to IDLE.
- Header held across a packet: valid_insert high during DATA is ignored.
- Reset (at any time, including mid-packet):
  - state=IDLE; R, H cleared.
  - valid_out=0, data_out=0, keep_out=0, last_out=0.
  - ready_in=0 and ready_insert=0 while reset is asserted.
  - Any in-flight packet is discarded.
- Undefined inputs: non-contiguous keep_insert or keep_in is unsupported; behaviour is unspecified but must not lock up (IDLE is reached after the last beat).

Test Plan:
- Scenario 1 (H=1):
  - Stimulus: data_insert=0xFFFFF0F0, keep_insert=0001; payload 0xFEC3F00C, then 0xFEC3F03C with last, keep_in=1110; ready_out=1.
  - Response: 0xF0FEC3F0 keep 1111 last 0, then 0x0CFEC3F0 keep 1111 last 1.
- Scenario 2 (H=2):
  - Stimulus: data_insert=0xAABBCCDD, keep_insert=0011; single payload beat 0x11223344, last, keep 1111.
  - Response: 0xCCDD1122 keep 1111 last 0, then 0x33440000 keep 1100 last 1 (TAIL state).
- Scenario 3 (H=0 pass-through):
  - Stimulus: keep_insert=0000; payload 0x12345678 with last, keep 1100.
  - Response: 0x12340000 keep 1100 last 1.
- Scenario 4 (H=4):
  - Stimulus: header 0xDEADBEEF, keep 1111; payload 0x01020304 with last, keep 1000.
  - Response: 0xDEADBEEF keep 1111, then 0x01000000 keep 1000 last 1.
- Scenario 5 (backpressure):
  - Stimulus: hold ready_out=0 for 3 cycles mid-packet.
  - Response: ready_in=0, output beat stable; no data lost or duplicated after release.
- Scenario 6 (reset mid-packet):
  - Stimulus: assert rst_n=1 mid-packet.
  - Response: next cycle valid_out=0, keep_out=0; after release ready_insert=1 and a new packet is processed correctly.

Source files
------------

// File: rtl/axi_stream_insert_header.sv
// AXI-Stream header inserter. The valid bytes of a per-packet header word are
// placed ahead of the payload bytes, and the merged byte stream is re-packed
// into full output beats. The output is a one-deep register slice.
module axi_stream_insert_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert
);

  // Byte counts run 0..N, and header+last-beat totals run up to 2N.
  localparam int CNT_WD = $clog2(DATA_BYTE_WD + 1);
  localparam int SUM_WD = CNT_WD + 1;
  localparam logic [CNT_WD-1:0] N_CNT = CNT_WD'(DATA_BYTE_WD);
  localparam logic [SUM_WD-1:0] N_SUM = SUM_WD'(DATA_BYTE_WD);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL} state_t;

  function automatic logic [CNT_WD-1:0] popcount(input logic [DATA_BYTE_WD-1:0] v);
    logic [CNT_WD-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CNT_WD'(v[i]);
    return c;
  endfunction

  // cnt ones packed against the MSB end (cnt = N gives all ones).
  function automatic logic [DATA_BYTE_WD-1:0] msb_keep(input logic [CNT_WD-1:0] cnt);
    return ~({DATA_BYTE_WD{1'b1}} >> cnt);
  endfunction

  state_t                    state_q, state_d;
  logic [DATA_WD-1:0]        res_q;        // leftover bytes, LSB-aligned
  logic [CNT_WD-1:0]         hlen_q;       // header length H of current packet
  logic [CNT_WD-1:0]         tail_cnt_q;   // bytes carried into the tail beat
  logic                      valid_out_q, valid_out_d;
  logic [DATA_WD-1:0]        data_out_q, data_out_d;
  logic [DATA_BYTE_WD-1:0]   keep_out_q, keep_out_d;
  logic                      last_out_q, last_out_d;

  logic                      hdr_fire, in_fire, tail_fire, out_free, load;
  logic [CNT_WD-1:0]         hdr_len, tail_sh;
  logic [SUM_WD-1:0]         tot;
  logic                      tail_needed;
  logic [2*DATA_WD-1:0]      wide;
  logic [DATA_WD-1:0]        merged, tail_data, raw_d, keep_mask;

  // The byte count input duplicates keep_insert and is not needed here.
  logic unused_byte_cnt;
  assign unused_byte_cnt = ^byte_insert_cnt;

  assign out_free    = !valid_out_q || ready_out;
  assign hdr_fire    = valid_insert && ready_insert;
  assign in_fire     = valid_in && ready_in;
  assign hdr_len     = popcount(keep_insert);
  assign tot         = SUM_WD'(hlen_q) + SUM_WD'(popcount(keep_in));
  assign tail_needed = tot > N_SUM;
  assign tail_sh     = N_CNT - hlen_q;

  // {R (H bytes), top N-H bytes of data_in}: shift the pair right by H bytes.
  assign wide      = {res_q, data_in} >> {hlen_q, 3'b000};
  assign merged    = wide[DATA_WD-1:0];
  assign tail_data = res_q << {tail_sh, 3'b000};

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hdr_fire) state_d = S_DATA;
      S_DATA:  if (in_fire && last_in) state_d = tail_needed ? S_TAIL : S_IDLE;
      S_TAIL:  if (tail_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs; everything is held off while reset is asserted.
  always_comb begin
    ready_insert = 1'b0;
    ready_in     = 1'b0;
    tail_fire    = 1'b0;
    if (!rst_n) begin
      case (state_q)
        S_IDLE:  ready_insert = 1'b1;
        S_DATA:  ready_in     = out_free;
        S_TAIL:  tail_fire    = out_free;
        default: ;
      endcase
    end
  end

  // Select the next output beat and its byte enables.
  always_comb begin
    load       = 1'b0;
    raw_d      = '0;
    keep_out_d = '0;
    last_out_d = 1'b0;
    if (in_fire) begin
      load  = 1'b1;
      raw_d = merged;
      if (last_in && !tail_needed) begin
        keep_out_d = msb_keep(CNT_WD'(tot));
        last_out_d = 1'b1;
      end else begin
        keep_out_d = '1;
      end
    end else if (tail_fire) begin
      load       = 1'b1;
      raw_d      = tail_data;
      keep_out_d = msb_keep(tail_cnt_q);
      last_out_d = 1'b1;
    end
  end

  // Expand byte enables to a bit mask so disabled bytes leave as zero.
  for (genvar gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_keep_mask
    assign keep_mask[gi*8 +: 8] = {8{keep_out_d[gi]}};
  end

  assign data_out_d  = raw_d & keep_mask;
  assign valid_out_d = load ? 1'b1 : (ready_out ? 1'b0 : valid_out_q);

  // Residual bytes, header length and the output register slice.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      res_q       <= '0;
      hlen_q      <= '0;
      tail_cnt_q  <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      keep_out_q  <= '0;
      last_out_q  <= 1'b0;
    end else begin
      if (hdr_fire) begin
        res_q  <= data_insert & ~({DATA_WD{1'b1}} << {hdr_len, 3'b000});
        hlen_q <= hdr_len;
      end else if (in_fire) begin
        res_q <= data_in & ~({DATA_WD{1'b1}} << {hlen_q, 3'b000});
        if (last_in && tail_needed) tail_cnt_q <= CNT_WD'(tot - N_SUM);
      end
      valid_out_q <= valid_out_d;
      if (load) begin
        data_out_q <= data_out_d;
        keep_out_q <= keep_out_d;
        last_out_q <= last_out_d;
      end
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign keep_out  = keep_out_q;
  assign last_out  = last_out_q;

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Randomised bench for axi_stream_insert_header. Expected output beats come
// from a byte-queue model: header bytes then payload bytes, cut into N-byte beats.
module tb_axi_stream_insert_header;

  localparam int DW = 32;
  localparam int NB = 4;
  localparam int CW = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [NB-1:0] keep_in = '1;
  logic          last_in = 1'b0;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [NB-1:0] keep_out;
  logic          last_out;
  logic          ready_out = 1'b1;
  logic          valid_insert = 1'b0;
  logic [DW-1:0] data_insert = '0;
  logic [NB-1:0] keep_insert = '0;
  logic [CW-1:0] byte_insert_cnt = '0;
  logic          ready_insert;

  int            n_checks = 0;
  int            n_fails = 0;
  beat_t         exp_q[$];
  logic [DW-1:0] pay[16];
  bit            rdy_rand = 0;
  bit            rdy_manual = 0;
  bit            mon_en = 1;

  axi_stream_insert_header #(.DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int popc(input logic [NB-1:0] v);
    int c = 0;
    for (int i = 0; i < NB; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic push_exp(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
    beat_t e;
    e.d = d; e.k = k; e.l = l;
    exp_q.push_back(e);
  endtask

  // Reference: concatenate byte streams, then slice into beats.
  task automatic model_pkt(input logic [DW-1:0] hdr, input logic [NB-1:0] hk,
                           input int nb, input logic [NB-1:0] lk);
    logic [7:0] bq[$];
    int h;
    int cnt;
    h = popc(hk);
    for (int i = h - 1; i >= 0; i--) bq.push_back(hdr[8*i +: 8]);
    for (int b = 0; b < nb; b++) begin
      cnt = (b == nb - 1) ? popc(lk) : NB;
      for (int j = 0; j < cnt; j++) bq.push_back(pay[b][DW-1-8*j -: 8]);
    end
    while (bq.size() > 0) begin
      beat_t e;
      int c;
      e.d = '0; e.k = '0; c = 0;
      while (c < NB && bq.size() > 0) begin
        e.d[DW-1-8*c -: 8] = bq.pop_front();
        e.k[NB-1-c] = 1'b1;
        c++;
      end
      e.l = (bq.size() == 0);
      exp_q.push_back(e);
    end
  endtask

  // Entered just after a rising edge with valid already driven; returns just
  // after the edge on which the transfer happened.
  task automatic wait_hs(input bit hdr, input string tag);
    int n = 0;
    @(negedge clk);
    while (!(hdr ? ready_insert : ready_in) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(hdr ? ready_insert : ready_in), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [DW-1:0] hdr, input logic [NB-1:0] hk, input int nb,
                          input logic [NB-1:0] lk, input bit use_model, input bit gaps);
    if (use_model) model_pkt(hdr, hk, nb, lk);
    valid_insert    = 1'b1;
    data_insert     = hdr;
    keep_insert     = hk;
    byte_insert_cnt = CW'(popc(hk));
    wait_hs(1'b1, "hdr_hs");
    valid_insert = 1'b0;
    data_insert  = $urandom;
    for (int b = 0; b < nb; b++) begin
      if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      valid_in = 1'b1;
      data_in  = pay[b];
      last_in  = (b == nb - 1);
      keep_in  = (b == nb - 1) ? lk : '1;
      wait_hs(1'b0, "in_hs");
      valid_in = 1'b0;
    end
    last_in = 1'b0;
    keep_in = '1;
    data_in = $urandom;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Downstream ready: always 1, or random when rdy_rand is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rdy_manual) ready_out = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare on each transfer, stability while stalled.
  initial begin
    beat_t         e;
    bit            hold = 0;
    logic [DW-1:0] hd;
    logic [NB-1:0] hk;
    logic          hl;
    forever begin
      @(negedge clk);
      if (rst_n || !mon_en) begin
        hold = 0;
      end else begin
        if (hold) begin
          check_val("hold_valid", 32'(valid_out), 32'd1);
          check_val("hold_data", data_out, hd);
          check_val("hold_keep", 32'(keep_out), 32'(hk));
          check_val("hold_last", 32'(last_out), 32'(hl));
        end
        if (valid_out && ready_out) begin
          if (exp_q.size() == 0) begin
            check_val("extra_beat", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            $display("beat data=%h keep=%b last=%b (exp %h %b %b)",
                     data_out, keep_out, last_out, e.d, e.k, e.l);
            check_val("out_data", data_out, e.d);
            check_val("out_keep", 32'(keep_out), 32'(e.k));
            check_val("out_last", 32'(last_out), 32'(e.l));
          end
        end
        hold = valid_out && !ready_out;
        hd = data_out; hk = keep_out; hl = last_out;
      end
    end
  end

  initial begin
    int            h, nb, k;
    logic [NB-1:0] hkr, lkr;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", 32'(valid_out), 32'd0);
    check_val("rst_data", data_out, 32'd0);
    check_val("rst_keep", 32'(keep_out), 32'd0);
    check_val("rst_last", 32'(last_out), 32'd0);
    check_val("rst_rdy_in", 32'(ready_in), 32'd0);
    check_val("rst_rdy_ins", 32'(ready_insert), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_val("idle_rdy_ins", 32'(ready_insert), 32'd1);
    check_val("idle_rdy_in", 32'(ready_in), 32'd0);
    @(posedge clk); #1;

    // Scenario 1: H=1, two payload beats.
    pay[0] = 32'hFEC3F00C; pay[1] = 32'hFEC3F03C;
    push_exp(32'hF0FEC3F0, 4'b1111, 1'b0);
    push_exp(32'h0CFEC3F0, 4'b1111, 1'b1);
    send_pkt(32'hFFFFF0F0, 4'b0001, 2, 4'b1110, 0, 0);
    // Scenario 2: H=2, tail beat.
    pay[0] = 32'h11223344;
    push_exp(32'hCCDD1122, 4'b1111, 1'b0);
    push_exp(32'h33440000, 4'b1100, 1'b1);
    send_pkt(32'hAABBCCDD, 4'b0011, 1, 4'b1111, 0, 0);
    // Scenario 3: H=0 pass-through.
    pay[0] = 32'h12345678;
    push_exp(32'h12340000, 4'b1100, 1'b1);
    send_pkt(32'h9ABCDEF0, 4'b0000, 1, 4'b1100, 0, 0);
    // Scenario 4: H=4.
    pay[0] = 32'h01020304;
    push_exp(32'hDEADBEEF, 4'b1111, 1'b0);
    push_exp(32'h01000000, 4'b1000, 1'b1);
    send_pkt(32'hDEADBEEF, 4'b1111, 1, 4'b1000, 0, 0);
    drain("drain_directed");

    // Scenario 5: three stalled cycles mid-packet.
    pay[0] = 32'h10203040; pay[1] = 32'h50607080; pay[2] = 32'h90A0B0C0;
    fork
      send_pkt(32'h000000A5, 4'b0001, 3, 4'b1111, 1, 0);
      begin
        int n5;
        n5 = 0;
        @(negedge clk);
        while (!valid_out && n5 < 100) begin @(negedge clk); n5++; end
        check_val("s5_seen", 32'(valid_out), 32'd1);
        @(posedge clk); #2;
        rdy_manual = 1; ready_out = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_val("s5_rdy_in", 32'(ready_in), 32'd0);
          check_val("s5_valid", 32'(valid_out), 32'd1);
        end
        @(posedge clk); #2;
        ready_out = 1'b1; rdy_manual = 0;
      end
    join
    drain("drain_bp");

    // Scenario 6: reset in the middle of a packet.
    mon_en = 0;
    valid_insert = 1'b1; data_insert = 32'h11223344; keep_insert = 4'b0011;
    wait_hs(1'b1, "s6_hdr");
    valid_insert = 1'b0;
    valid_in = 1'b1; data_in = 32'hAAAAAAAA; keep_in = '1; last_in = 1'b0;
    wait_hs(1'b0, "s6_in");
    valid_in = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("s6_rdy_in_rst", 32'(ready_in), 32'd0);
    check_val("s6_rdy_ins_rst", 32'(ready_insert), 32'd0);
    @(negedge clk);
    check_val("s6_valid", 32'(valid_out), 32'd0);
    check_val("s6_keep", 32'(keep_out), 32'd0);
    check_val("s6_data", data_out, 32'd0);
    check_val("s6_last", 32'(last_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0; mon_en = 1;
    @(negedge clk);
    check_val("s6_rdy_ins", 32'(ready_insert), 32'd1);
    @(posedge clk); #1;
    pay[0] = 32'h55667788; pay[1] = 32'h99AABBCC;
    send_pkt(32'h00EEFF00, 4'b0111, 2, 4'b1100, 1, 0);
    drain("drain_rst");

    // Randomised packets with input gaps and random downstream ready.
    rdy_rand = 1;
    for (int p = 0; p < 40; p++) begin
      h   = $urandom_range(0, NB);
      nb  = $urandom_range(1, 4);
      k   = $urandom_range(1, NB);
      hkr = NB'((32'd1 << h) - 1);
      lkr = NB'((32'hF << (NB - k)) & 32'hF);
      for (int b = 0; b < nb; b++) pay[b] = $urandom;
      send_pkt($urandom, hkr, nb, lkr, 1, 1);
    end
    rdy_rand = 0;
    drain("drain_rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
